// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared fixed-point types, saturation constants, the
//               saturating adder and the reducer record layout.
//               Optional macro ALU_REDUCER_MIN_EN adds a min field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int INT_W     = 3;
   localparam int FRAC_W    = 5;
   localparam int DATA_W    = INT_W + FRAC_W;
   // Record count field is sized for the largest legal block (255 elements).
   localparam int CNT_REC_W = 8;

   typedef logic signed [DATA_W-1:0] fx_t;

   localparam fx_t FX_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam fx_t FX_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   function automatic logic add_ovf(input fx_t a, input fx_t b);
      logic [DATA_W:0] s;
      s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      return s[DATA_W] != s[DATA_W-1];
   endfunction

   function automatic fx_t sat_add(input fx_t a, input fx_t b);
      logic [DATA_W:0] s;
      s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      if (s[DATA_W] != s[DATA_W-1]) begin
         return s[DATA_W] ? FX_MIN : FX_MAX;
      end
      return s[DATA_W-1:0];
   endfunction

   typedef struct packed {
      fx_t                  sum;
      fx_t                  max;
`ifdef ALU_REDUCER_MIN_EN
      fx_t                  min;
`endif
      logic [CNT_REC_W-1:0] cnt;
      logic                 sat;
   } red_rec_t;

   localparam int REC_W = $bits(red_rec_t);

endpackage

`default_nettype wire

// File: rtl/reducer_fifo2.sv
// ============================================================================
// Module      : reducer_fifo2
// Description : Two-entry in-order synchronous FIFO of reducer records;
//               a push into a full FIFO is accepted when a pop frees the slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reducer_fifo2
   import alu_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [REC_W-1:0] i_din,
   input  logic             i_pop,
   output logic [REC_W-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   logic [REC_W-1:0] mem_q [2];
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_empty   = (count_q == 2'd0);
   assign o_full    = (count_q == 2'd2);
   assign o_dout    = mem_q[rd_ptr_q];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_comb begin
      count_d = count_q;
      unique case ({w_do_push, w_do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // When full, wr_ptr equals rd_ptr, so a push+pop overwrites the departing head.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < 2; k++) begin
            mem_q[k] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (w_do_push) begin
            mem_q[wr_ptr_q] <= i_din;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (w_do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_result_reducer.sv
// ============================================================================
// Module      : alu_result_reducer
// Description : Groups ALU results into blocks, emits saturated sum / max
//               records through a 2-entry FIFO. ALU_REDUCER_MIN_EN adds o_min.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_reducer
   import alu_pkg::*;
#(
   parameter int BLK_LEN = 4,
   parameter int CNT_W   = $clog2(BLK_LEN + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_flush,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_sum,
   output logic [DATA_W-1:0] o_max,
`ifdef ALU_REDUCER_MIN_EN
   output logic [DATA_W-1:0] o_min,
`endif
   output logic [CNT_W-1:0]  o_cnt,
   output logic              o_sat,
   output logic              o_overflow
);

   fx_t              w_data;
   fx_t              acc_q,  acc_d,  w_acc_n;
   fx_t              mx_q,   mx_d,   w_mx_n;
   logic [CNT_W-1:0] cnt_q,  cnt_d,  w_cnt_n;
   logic             sat_q,  sat_d,  w_sat_n;
`ifdef ALU_REDUCER_MIN_EN
   fx_t              mn_q,   mn_d,   w_mn_n;
`endif
   logic             ovf_q,  ovf_d;
   logic             w_close;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_drop;
   red_rec_t         w_rec;
   red_rec_t         w_head;
   logic [REC_W-1:0] w_fifo_dout;
   logic             w_unused_cnt;

   assign w_data = $signed(i_data);

   // Element-updated accumulator values, before any block close.
   always_comb begin
      w_acc_n = acc_q;
      w_mx_n  = mx_q;
      w_cnt_n = cnt_q;
      w_sat_n = sat_q;
`ifdef ALU_REDUCER_MIN_EN
      w_mn_n  = mn_q;
`endif
      if (i_valid) begin
         w_acc_n = sat_add(acc_q, w_data);
         w_sat_n = sat_q | add_ovf(acc_q, w_data);
         w_mx_n  = ((cnt_q == '0) || (w_data > mx_q)) ? w_data : mx_q;
`ifdef ALU_REDUCER_MIN_EN
         w_mn_n  = ((cnt_q == '0) || (w_data < mn_q)) ? w_data : mn_q;
`endif
         w_cnt_n = cnt_q + CNT_W'(1);
      end
   end

   assign w_close = (i_valid & (w_cnt_n == CNT_W'(BLK_LEN)))
                  | (i_flush & (w_cnt_n != '0));

   always_comb begin
      w_rec     = '0;
      w_rec.sum = w_acc_n;
      w_rec.max = w_mx_n;
`ifdef ALU_REDUCER_MIN_EN
      w_rec.min = w_mn_n;
`endif
      w_rec.cnt = CNT_REC_W'(w_cnt_n);
      w_rec.sat = w_sat_n;
   end

   // Stale mx/min after a close are harmless: cnt==0 forces a reload.
   always_comb begin
      acc_d = w_acc_n;
      mx_d  = w_mx_n;
      cnt_d = w_cnt_n;
      sat_d = w_sat_n;
`ifdef ALU_REDUCER_MIN_EN
      mn_d  = w_mn_n;
`endif
      if (w_close) begin
         acc_d = '0;
         cnt_d = '0;
         sat_d = 1'b0;
      end
   end

   assign w_pop  = ~w_empty & i_ready;
   assign w_drop = w_close & w_full & ~w_pop;
   assign ovf_d  = ovf_q | w_drop;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q <= '0;
         mx_q  <= '0;
         cnt_q <= '0;
         sat_q <= 1'b0;
`ifdef ALU_REDUCER_MIN_EN
         mn_q  <= '0;
`endif
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         mx_q  <= mx_d;
         cnt_q <= cnt_d;
         sat_q <= sat_d;
`ifdef ALU_REDUCER_MIN_EN
         mn_q  <= mn_d;
`endif
         ovf_q <= ovf_d;
      end
   end

   reducer_fifo2 u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_close),
      .i_din   (w_rec),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head       = w_fifo_dout;
   assign w_unused_cnt = ^w_head.cnt;

   assign o_valid    = ~w_empty;
   assign o_sum      = w_head.sum;
   assign o_max      = w_head.max;
`ifdef ALU_REDUCER_MIN_EN
   assign o_min      = w_head.min;
`endif
   assign o_cnt      = w_head.cnt[CNT_W-1:0];
   assign o_sat      = w_head.sat;
   assign o_overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_reducer.sv
// ============================================================================
// Module      : tb_alu_result_reducer
// Description : Directed plus random stimulus against a queue-based
//               reference model of block reduction and the output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_reducer;

   localparam int DW      = alu_pkg::DATA_W;
   localparam int BLK_LEN = 4;
   localparam int CNT_W   = $clog2(BLK_LEN + 1);
   localparam int MAXV    = (1 << (DW - 1)) - 1;
   localparam int MINV    = -(1 << (DW - 1));
   localparam int MASK    = (1 << DW) - 1;

   logic            clk;
   logic            i_rst;
   logic            i_valid;
   logic [DW-1:0]   i_data;
   logic            i_flush;
   logic            i_ready;
   logic            o_valid;
   logic [DW-1:0]   o_sum;
   logic [DW-1:0]   o_max;
`ifdef ALU_REDUCER_MIN_EN
   logic [DW-1:0]   o_min;
`endif
   logic [CNT_W-1:0] o_cnt;
   logic            o_sat;
   logic            o_overflow;

   alu_result_reducer #(.BLK_LEN(BLK_LEN)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .i_flush    (i_flush),
      .i_ready    (i_ready),
      .o_valid    (o_valid),
      .o_sum      (o_sum),
      .o_max      (o_max),
`ifdef ALU_REDUCER_MIN_EN
      .o_min      (o_min),
`endif
      .o_cnt      (o_cnt),
      .o_sat      (o_sat),
      .o_overflow (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int sum;
      int mx;
      int mn;
      int cnt;
      bit sat;
   } mrec_t;

   mrec_t mq[$];
   int    blk[$];
   bit    m_ovf;
   int    n_chk;
   int    n_fail;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int to_s(input logic [DW-1:0] d);
      return int'($signed(d));
   endfunction

   // Running sum clamped after every addition, matching sticky saturation.
   function automatic mrec_t reduce_blk();
      mrec_t r;
      r.sum = 0;
      r.sat = 1'b0;
      r.cnt = blk.size();
      r.mx  = blk[0];
      r.mn  = blk[0];
      foreach (blk[k]) begin
         r.sum = r.sum + blk[k];
         if (r.sum > MAXV) begin
            r.sum = MAXV;
            r.sat = 1'b1;
         end else if (r.sum < MINV) begin
            r.sum = MINV;
            r.sat = 1'b1;
         end
         if (blk[k] > r.mx) r.mx = blk[k];
         if (blk[k] < r.mn) r.mn = blk[k];
      end
      return r;
   endfunction

   task automatic compare_model();
      chk("o_valid", 32'(o_valid), 32'(mq.size() != 0));
      chk("o_overflow", 32'(o_overflow), 32'(m_ovf));
      if (mq.size() != 0) begin
         chk("o_sum", 32'(o_sum), 32'(mq[0].sum & MASK));
         chk("o_max", 32'(o_max), 32'(mq[0].mx & MASK));
`ifdef ALU_REDUCER_MIN_EN
         chk("o_min", 32'(o_min), 32'(mq[0].mn & MASK));
`endif
         chk("o_cnt", 32'(o_cnt), 32'(mq[0].cnt));
         chk("o_sat", 32'(o_sat), 32'(mq[0].sat));
      end
   endtask

   task automatic step(input bit v, input int d, input bit f, input bit r, input bit rs);
      bit    popping;
      bit    close;
      mrec_t rec;
      i_valid = v;
      i_data  = d[DW-1:0];
      i_flush = f;
      i_ready = r;
      i_rst   = rs;
      @(posedge clk);
      if (rs) begin
         blk.delete();
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         popping = (mq.size() != 0) && r;
         if (v) blk.push_back(to_s(d[DW-1:0]));
         close = (v && blk.size() == BLK_LEN) || (f && blk.size() != 0);
         if (close) begin
            rec = reduce_blk();
            blk.delete();
         end
         if (popping) void'(mq.pop_front());
         if (close) begin
            if (mq.size() < 2) mq.push_back(rec);
            else m_ovf = 1'b1;
         end
      end
      @(negedge clk);
      compare_model();
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      m_ovf   = 1'b0;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      i_flush = 1'b0;
      i_ready = 1'b0;
      @(negedge clk);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_sum", 32'(o_sum), 32'd0);
      chk("rst_max", 32'(o_max), 32'd0);
      chk("rst_cnt", 32'(o_cnt), 32'd0);
      chk("rst_sat", 32'(o_sat), 32'd0);
      chk("rst_ovf", 32'(o_overflow), 32'd0);

      // Basic block
      step(1, 'h10, 0, 1, 0);
      step(1, 'h08, 0, 1, 0);
      step(1, 'hF8, 0, 1, 0);
      step(1, 'h20, 0, 1, 0);
      chk("basic_valid", 32'(o_valid), 32'd1);
      chk("basic_sum", 32'(o_sum), 32'h30);
      chk("basic_max", 32'(o_max), 32'h20);
      chk("basic_cnt", 32'(o_cnt), 32'd4);
      chk("basic_sat", 32'(o_sat), 32'd0);
`ifdef ALU_REDUCER_MIN_EN
      chk("basic_min", 32'(o_min), 32'hF8);
`endif

      // Positive and negative saturation
      for (int k = 0; k < 4; k++) step(1, 'h20, 0, 1, 0);
      chk("psat_sum", 32'(o_sum), 32'h7F);
      chk("psat_sat", 32'(o_sat), 32'd1);
      for (int k = 0; k < 4; k++) step(1, 'hC0, 0, 1, 0);
      chk("nsat_sum", 32'(o_sum), 32'h80);
      chk("nsat_sat", 32'(o_sat), 32'd1);

      // Flush with data in the same cycle, then an empty flush
      step(1, 'h05, 0, 1, 0);
      step(1, 'h03, 1, 1, 0);
      chk("flush_sum", 32'(o_sum), 32'h08);
      chk("flush_cnt", 32'(o_cnt), 32'd2);
      chk("flush_max", 32'(o_max), 32'h05);
      step(0, 0, 1, 1, 0);
      chk("flush_empty", 32'(o_valid), 32'd0);

      // Backpressure: third block dropped
      for (int k = 1; k <= 12; k++) step(1, k, 0, 0, 0);
      chk("ovf_set", 32'(o_overflow), 32'd1);
      chk("ovf_head1", 32'(o_sum), 32'd10);
      step(0, 0, 0, 1, 0);
      chk("ovf_head2", 32'(o_sum), 32'd26);
      step(0, 0, 0, 1, 0);
      chk("ovf_drained", 32'(o_valid), 32'd0);
      chk("ovf_sticky", 32'(o_overflow), 32'd1);

      // Full FIFO with push and pop on the same edge
      step(0, 0, 0, 1, 1);
      for (int k = 1; k <= 11; k++) step(1, k, 0, 0, 0);
      step(1, 12, 0, 1, 0);
      chk("pp_no_ovf", 32'(o_overflow), 32'd0);
      chk("pp_head2", 32'(o_sum), 32'd26);
      step(0, 0, 0, 1, 0);
      chk("pp_head3", 32'(o_sum), 32'd42);
      step(0, 0, 0, 1, 0);
      chk("pp_drained", 32'(o_valid), 32'd0);

      // Reset mid-block
      step(1, 'h33, 0, 1, 0);
      step(1, 'h22, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      for (int k = 0; k < 4; k++) step(1, 'h01, 0, 1, 0);
      chk("mrst_sum", 32'(o_sum), 32'd4);
      chk("mrst_cnt", 32'(o_cnt), 32'd4);
      step(0, 0, 0, 1, 0);
      chk("mrst_single", 32'(o_valid), 32'd0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 9) < 7, int'($urandom_range(0, MASK)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 199) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
